// File: rtl/multicycle_control.sv
// Multi-cycle control unit: sequences each instruction through FETCH..WB.
// It stretches EXEC for mul and MEM for loads, and counts busy cycles.
module multicycle_control #(
    parameter int MCODEBITS  = 9,
    parameter int OPWIDTH    = 4,
    parameter int MUL_CYCLES = 2,
    parameter int MEM_LAT    = 1,
    parameter int CNT_W      = 16
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic                 start,
    input  logic [MCODEBITS-1:0] instr,
    output logic                 done,
    output logic                 busy,
    output logic                 pc_en,
    output logic                 Branch,
    output logic                 MemWrite,
    output logic                 MemRead,
    output logic                 ALUSrc,
    output logic                 RegWrite,
    output logic                 MemtoReg,
    output logic                 MemSrc,
    output logic [OPWIDTH-1:0]   ALUOp,
    output logic [3:0]           regA,
    output logic [3:0]           regB,
    output logic [3:0]           wr_addr,
    output logic [4:0]           immed,
    output logic [CNT_W-1:0]     cycle_count
);

    typedef enum logic [2:0] {
        S_IDLE, S_FETCH, S_DECODE, S_EXEC, S_MEM, S_WB, S_HALT
    } state_t;

    localparam int MAXC = (MUL_CYCLES > MEM_LAT) ? MUL_CYCLES : MEM_LAT;
    localparam int SW   = (MAXC > 1) ? $clog2(MAXC) : 1;

    state_t               state_q, state_d;
    logic [MCODEBITS-1:0] ir_q, ir_d;
    logic [SW-1:0]        stall_q, stall_d;
    logic [CNT_W-1:0]     cnt_q, cnt_d;
    logic                 done_q, done_d;

    logic [2:0] op;
    logic [1:0] fn;
    logic       is_mul, is_halt, is_ld, is_st, is_br;

    assign op      = ir_q[8:6];
    assign fn      = ir_q[5:4];
    assign is_mul  = (op == 3'b111) && (fn == 2'b10);
    assign is_halt = (op == 3'b111) && (fn == 2'b11);
    assign is_ld   = ((op == 3'b000) && (fn == 2'b10)) || (op == 3'b001);
    assign is_st   = ((op == 3'b000) && (fn == 2'b11)) || (op == 3'b010);
    assign is_br   = (op == 3'b100);

    always_comb begin
        state_d = state_q;
        ir_d    = ir_q;
        stall_d = stall_q;
        cnt_d   = cnt_q;
        unique case (state_q)
            S_IDLE:   if (start) state_d = S_FETCH;
            S_FETCH: begin
                ir_d    = instr;
                state_d = S_DECODE;
            end
            S_DECODE: begin
                if (is_halt) begin
                    state_d = S_HALT;
                end else begin
                    state_d = S_EXEC;
                    stall_d = is_mul ? SW'(MUL_CYCLES - 1) : '0;
                end
            end
            S_EXEC: begin
                if (stall_q != '0) begin
                    stall_d = stall_q - 1'b1;
                end else if (is_br) begin
                    state_d = S_FETCH;
                end else if (is_ld || is_st) begin
                    state_d = S_MEM;
                    stall_d = is_ld ? SW'(MEM_LAT - 1) : '0;
                end else begin
                    state_d = S_WB;
                end
            end
            S_MEM: begin
                if (stall_q != '0) stall_d = stall_q - 1'b1;
                else if (is_st)    state_d = S_FETCH;
                else               state_d = S_WB;
            end
            S_WB:     state_d = S_FETCH;
            S_HALT:   if (start) state_d = S_FETCH;
            default:  state_d = S_IDLE;
        endcase
        // A start accepted from IDLE/HALT restarts the count; otherwise
        // every busy cycle counts until the counter pins at all-ones.
        if ((state_q == S_IDLE || state_q == S_HALT) && start) begin
            cnt_d = '0;
        end else if (busy && cnt_q != '1) begin
            cnt_d = cnt_q + 1'b1;
        end
        done_d = (state_d == S_HALT);
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= S_IDLE;
            ir_q    <= '0;
            stall_q <= '0;
            cnt_q   <= '0;
            done_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            ir_q    <= ir_d;
            stall_q <= stall_d;
            cnt_q   <= cnt_d;
            done_q  <= done_d;
        end
    end

    logic in_ew;
    assign in_ew = (state_q == S_EXEC) || (state_q == S_WB);

    always_comb begin
        ALUOp    = '1;
        regA     = 4'd0;
        regB     = 4'd1;
        wr_addr  = ir_q[3:0];
        immed    = ir_q[5:1];
        Branch   = 1'b0;
        MemWrite = 1'b0;
        MemRead  = 1'b0;
        ALUSrc   = 1'b0;
        RegWrite = 1'b0;
        MemtoReg = 1'b0;
        MemSrc   = 1'b0;
        pc_en    = 1'b0;
        if (op == 3'b101) begin
            regA    = ir_q[4:1];
            wr_addr = {3'b000, ir_q[5]};
        end
        if (op == 3'b010) regA = {3'b000, ir_q[0]};
        if (op == 3'b001) wr_addr = {3'b000, ir_q[0]};
        if (op == 3'b000 && fn == 2'b11) regB = ir_q[3:0];
        if (in_ew) begin
            case (op)
                3'b000: if (!fn[1]) ALUOp = OPWIDTH'({3'b000, fn[0]});
                3'b110: ALUOp = OPWIDTH'({2'b00, fn} + 4'd2);
                3'b111: if (fn != 2'b11) ALUOp = OPWIDTH'({2'b00, fn} + 4'd6);
                default: ;
            endcase
            ALUSrc = (op == 3'b011);
        end
        RegWrite = (state_q == S_WB);
        MemRead  = (state_q == S_MEM) && is_ld;
        MemtoReg = is_ld && ((state_q == S_MEM) || (state_q == S_WB));
        MemWrite = (state_q == S_MEM) && is_st;
        MemSrc   = (state_q == S_MEM) && ((op == 3'b001) || (op == 3'b010));
        Branch   = (state_q == S_EXEC) && is_br;
        pc_en    = (state_q == S_WB) || MemWrite || Branch;
    end

    assign busy        = (state_q != S_IDLE) && (state_q != S_HALT);
    assign done        = done_q;
    assign cycle_count = cnt_q;

endmodule

// File: tb/tb_multicycle_control.sv
// Bench for multicycle_control: directed program plus random instruction
// stream, checked every cycle against a phase-level reference model.
module tb_multicycle_control;

    localparam int MUL_C = 3;
    localparam int MEM_L = 2;
    localparam int CW    = 5;
    localparam int CMAX  = (1 << CW) - 1;

    localparam int P_IDLE   = 0;
    localparam int P_FETCH  = 1;
    localparam int P_DECODE = 2;
    localparam int P_EXEC   = 3;
    localparam int P_MEM    = 4;
    localparam int P_WB     = 5;
    localparam int P_HALT   = 6;

    logic          clk = 1'b0;
    logic          reset;
    logic          start;
    logic [8:0]    instr;
    logic          done, busy, pc_en;
    logic          Branch, MemWrite, MemRead, ALUSrc;
    logic          RegWrite, MemtoReg, MemSrc;
    logic [3:0]    ALUOp, regA, regB, wr_addr;
    logic [4:0]    immed;
    logic [CW-1:0] cycle_count;

    int         total = 0;
    int         bad   = 0;
    logic [8:0] m_ir;
    int         mcount;

    always #5 clk = ~clk;

    multicycle_control #(
        .MCODEBITS (9),
        .OPWIDTH   (4),
        .MUL_CYCLES(MUL_C),
        .MEM_LAT   (MEM_L),
        .CNT_W     (CW)
    ) dut (
        .clk        (clk),
        .reset      (reset),
        .start      (start),
        .instr      (instr),
        .done       (done),
        .busy       (busy),
        .pc_en      (pc_en),
        .Branch     (Branch),
        .MemWrite   (MemWrite),
        .MemRead    (MemRead),
        .ALUSrc     (ALUSrc),
        .RegWrite   (RegWrite),
        .MemtoReg   (MemtoReg),
        .MemSrc     (MemSrc),
        .ALUOp      (ALUOp),
        .regA       (regA),
        .regB       (regB),
        .wr_addr    (wr_addr),
        .immed      (immed),
        .cycle_count(cycle_count)
    );

    task automatic cmp(input string tag, input int ph,
                       input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s phase=%0d got=%0h want=%0h", tag, ph, obs, exp);
        end
    endtask

    // One clock cycle in phase ph: predict outputs from the spec's rules,
    // compare mid-cycle, then advance the model across the edge.
    task automatic cyc(input int ph);
        logic [2:0] op;
        logic [1:0] fn;
        bit         ld, st, ew, mem, wb, ex, e_busy;
        int         e_alu;
        logic [3:0] e_ra, e_rb, e_wr;
        op  = m_ir[8:6];
        fn  = m_ir[5:4];
        ld  = (op == 0 && fn == 2) || op == 1;
        st  = (op == 0 && fn == 3) || op == 2;
        ex  = (ph == P_EXEC);
        mem = (ph == P_MEM);
        wb  = (ph == P_WB);
        ew  = ex || wb;
        e_busy = (ph != P_IDLE) && (ph != P_HALT);
        e_alu = 15;
        if (ew) begin
            if (op == 0 && fn < 2)      e_alu = fn;
            else if (op == 6)           e_alu = 2 + fn;
            else if (op == 7 && fn < 3) e_alu = 6 + fn;
        end
        e_ra = (op == 5) ? m_ir[4:1] : (op == 2) ? {3'b0, m_ir[0]} : 4'd0;
        e_rb = (op == 0 && fn == 3) ? m_ir[3:0] : 4'd1;
        e_wr = (op == 1) ? {3'b0, m_ir[0]} :
               (op == 5) ? {3'b0, m_ir[5]} : m_ir[3:0];
        @(negedge clk);
        cmp("status", ph, {done, busy, pc_en},
            {ph == P_HALT, e_busy,
             wb || (mem && st) || (ex && op == 4)});
        cmp("ctrl", ph,
            {Branch, MemWrite, MemRead, ALUSrc, RegWrite, MemtoReg, MemSrc},
            {ex && op == 4, mem && st, mem && ld, ew && op == 3, wb,
             ld && (mem || wb), mem && (op == 1 || op == 2)});
        cmp("aluop", ph, ALUOp, e_alu);
        cmp("regs", ph, {regA, regB, wr_addr, immed},
            {e_ra, e_rb, e_wr, m_ir[5:1]});
        cmp("count", ph, cycle_count, mcount);
        @(posedge clk);
        if (reset) begin
            m_ir   = '0;
            mcount = 0;
        end else begin
            if (ph == P_FETCH) m_ir = instr;
            if ((ph == P_IDLE || ph == P_HALT) && start) mcount = 0;
            else if (e_busy && mcount < CMAX) mcount++;
        end
        #1;
    endtask

    // Runs one instruction starting in FETCH; start toggles randomly
    // while busy since it must be ignored there.
    task automatic run_instr(input logic [8:0] ins);
        logic [2:0] op;
        logic [1:0] fn;
        op = ins[8:6];
        fn = ins[5:4];
        instr = ins;
        start = 1'($urandom_range(0, 1));
        cyc(P_FETCH);
        instr = 9'($urandom);
        start = 1'($urandom_range(0, 1));
        cyc(P_DECODE);
        if (!(op == 7 && fn == 3)) begin
            repeat ((op == 7 && fn == 2) ? MUL_C : 1) begin
                start = 1'($urandom_range(0, 1));
                cyc(P_EXEC);
            end
            if (op != 4) begin
                if ((op == 0 && fn == 3) || op == 2) begin
                    cyc(P_MEM);
                end else begin
                    if ((op == 0 && fn == 2) || op == 1)
                        repeat (MEM_L) cyc(P_MEM);
                    start = 1'($urandom_range(0, 1));
                    cyc(P_WB);
                end
            end
        end
        start = 1'b0;
    endtask

    task automatic halt_wait(input int k);
        start = 1'b0;
        repeat (k) cyc(P_HALT);
        start = 1'b1;
        cyc(P_HALT);
        start = 1'b0;
    endtask

    initial begin
        logic [8:0] ins;
        reset  = 1'b1;
        start  = 1'b0;
        instr  = '0;
        m_ir   = '0;
        mcount = 0;
        @(posedge clk);
        #1;
        cyc(P_IDLE);
        reset = 1'b0;
        cyc(P_IDLE);
        cyc(P_IDLE);

        start = 1'b1;
        cyc(P_IDLE);
        start = 1'b0;
        run_instr(9'b000_00_0011);
        run_instr(9'b111_10_0010);
        run_instr(9'b001_00101_1);
        run_instr(9'b010_00101_0);
        run_instr(9'b100_101010);
        run_instr(9'b111_11_0000);
        halt_wait(3);

        for (int i = 0; i < 60; i++) begin
            ins = 9'($urandom);
            run_instr(ins);
            if (ins[8:4] == 5'b11111) halt_wait($urandom_range(0, 2));
        end
        run_instr(9'b111_11_0001);
        halt_wait(1);

        instr = 9'b000_11_0101;
        cyc(P_FETCH);
        instr = 9'($urandom);
        cyc(P_DECODE);
        cyc(P_EXEC);
        reset = 1'b1;
        cyc(P_MEM);
        reset = 1'b0;
        cyc(P_IDLE);
        cyc(P_IDLE);
        start = 1'b1;
        cyc(P_IDLE);
        start = 1'b0;
        run_instr(9'b101_10110_0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/multicycle_control.md
# multicycle_control

Parametrised multi-cycle successor to the single-cycle control decoder. A state machine sequences each 9-bit instruction through FETCH, DECODE, EXEC, MEM and WB. It holds the instruction in an internal register and stretches EXEC for multiplies and MEM for slow data memory. It also provides a start/done handshake, a halt instruction and a saturating cycle counter. It sits between instruction memory, the register file, the ALU, data memory and the PC.

## Interface
- MCODEBITS, 9, instruction width (opcode [8:6], funct [5:4])
- OPWIDTH, 4, ALUOp width
- MUL_CYCLES, 2, EXEC cycles for mul (>=1)
- MEM_LAT, 1, MEM cycles for loads (>=1)
- CNT_W, 16, cycle counter width

Ports (one clock `clk`; `reset` is synchronous and active-high):
- clk  in  1  clock
- reset  in  1  synchronous, active-high
- start  in  1  begin/restart program
- instr  in  MCODEBITS  instruction memory output, valid during FETCH
- done  out  1  high in HALT
- busy  out  1  high in any state except IDLE/HALT
- pc_en  out  1  one-cycle PC advance pulse
- Branch, MemWrite, MemRead, ALUSrc, RegWrite, MemtoReg, MemSrc  out  1 each  datapath controls
- ALUOp  out  OPWIDTH  ALU operation
- regA, regB, wr_addr  out  4 each  register addresses
- immed  out  5  ir[5:1]
- cycle_count  out  CNT_W  executed cycles

## Operation
States and transitions:
- IDLE: go to FETCH on start.
- FETCH: go to DECODE.
- DECODE: go to EXEC, or to HALT if ir is 111/11.
- EXEC: branch goes to FETCH. Load/store goes to MEM. Everything else goes to WB.
- MEM: store goes to FETCH. Load goes to WB after MEM_LAT cycles.
- WB: go to FETCH.
- HALT: go to FETCH on start.

Instruction register and field decode:
- ir loads from instr at the end of FETCH only.
- All fields decode from ir.

Control outputs are combinational from state and ir, and are zero outside the listed states.
- Defaults: ALUOp=4'b1111, regA=0, regB=1, wr_addr=ir[3:0].
- ALU ops, in EXEC and WB: 000/00 gives ALUOp 0; 000/01 gives 1; 110/00..11 give 2..5; 111/00 gives 6; 111/01 gives 7; 111/10 (mul) gives 8. RegWrite is asserted in WB only.
- addi (011): ALUSrc=1 in EXEC and WB. RegWrite in WB.
- Register load (000/10): MemRead in MEM. MemtoReg=1 in MEM and WB. RegWrite in WB.
- Register store (000/11): regB=ir[3:0]. MemWrite=1 during the single MEM cycle.
- lb (001): MemSrc=1 and MemRead in MEM. wr_addr={3'b0,ir[0]}. MemtoReg=1. RegWrite in WB.
- sb (010): MemSrc=1. regA={3'b0,ir[0]}. MemWrite in MEM.
- Branch (100): Branch=1 for the single EXEC cycle.
- Move (101): regA=ir[4:1]. wr_addr={3'b0,ir[5]}. RegWrite in WB.

Other behaviour:
- pc_en pulses in the final cycle of each instruction: WB, the store's MEM cycle, or the branch's EXEC cycle. Halt never pulses pc_en.
- cycle_count clears when start is accepted and increments while busy. It saturates at all-ones.

## Timing
- Reset state: IDLE, ir=0, cycle_count=0. done, busy, pc_en and all 1-bit controls are 0. ALUOp=4'b1111, regA=0, regB=1.
- Reset has priority over start and over any state. If asserted mid-instruction, the next state is IDLE, no RegWrite or MemWrite follows, and ir is not reloaded.
- Cycles per instruction:
  - ALU, addi, move: 4
  - mul: 3+MUL_CYCLES
  - load: 4+MEM_LAT
  - store: 4
  - branch: 3
  - halt: 3 cycles to reach HALT
- EXEC stretch uses an internal down-counter reloaded on entry. For mul with MUL_CYCLES=1, EXEC lasts exactly one cycle.
- start is ignored while busy.
- done is registered. It rises the cycle after DECODE of halt and falls the cycle after start is accepted.
- Control signals are stable for the entire state duration, including stretched cycles.

## Test plan
- Reset held 2 cycles, then released with start=0. Required: IDLE, all outputs at reset values, cycle_count=0.
- start, instr=9'b000_00_0011 (add into R3). Required: pc_en exactly at cycle 4, ALUOp=0 in EXEC and WB, RegWrite only in WB with wr_addr=3.
- MUL_CYCLES=3, instr=9'b111_10_0010. Required: ALUOp=8 held for 3 EXEC cycles, RegWrite in WB, pc_en at cycle 6.
- MEM_LAT=2 with lb 9'b001_00101_1, then sb 9'b010_00101_0. For lb: MemSrc=1, MemRead for 2 cycles, wr_addr=1, MemtoReg=1 and RegWrite in WB. For sb: regA=0, MemWrite exactly 1 cycle, RegWrite never.
- Branch 9'b100_xxxxxx, then halt 9'b111_11_0000. For the branch: Branch and pc_en coincide in cycle 3. For the halt: done=1, busy=0, cycle_count frozen. start then re-enters FETCH and clears cycle_count.
- Reset asserted during the MEM cycle of a store. Required: no MemWrite on the following cycle, state IDLE.
